// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - multi-channel programmable clock-enable divider
module multi_clock_divider #(
  parameter int CHANNELS      = 2,
  parameter int WIDTH         = 16,
  parameter int DEFAULT_RATIO = 10,
  parameter int DEFAULT_HIGH  = DEFAULT_RATIO / 2,
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_ratio,
  input  logic [WIDTH-1:0]    wr_high,
  output logic [CHANNELS-1:0] divided,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] HIGH_RST  = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [CW:0]      CH_LIMIT  = (CW + 1)'(CHANNELS);

  logic             wr_valid;
  logic [WIDTH-1:0] wr_ratio_fix;

  // Writes aimed past the last channel are dropped; a zero ratio means one cycle.
  assign wr_valid     = wr_en && ({1'b0, wr_ch} < CH_LIMIT);
  assign wr_ratio_fix = (wr_ratio == '0) ? ONE : wr_ratio;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ratio_act, high_act;
    logic [WIDTH-1:0] ratio_sh, high_sh;
    logic             div_q, tick_q, pend_q;
    logic             restart, reload, wr_hit;

    // Sync and disable both force a fresh period; >= keeps a shrunk ratio safe.
    assign restart = sync || !en[i];
    assign reload  = restart || (cnt_q >= ratio_act);
    assign wr_hit  = wr_valid && (wr_ch == CW'(i));

    // Counter, outputs and shadow/active config; a same-cycle write lands after the reload.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= ONE;
        ratio_act <= RATIO_RST;
        high_act  <= HIGH_RST;
        ratio_sh  <= RATIO_RST;
        high_sh   <= HIGH_RST;
        div_q     <= 1'b0;
        tick_q    <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        if (restart) begin
          div_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          div_q  <= (cnt_q <= high_act);
          tick_q <= (cnt_q == ONE);
        end
        if (reload) begin
          cnt_q <= ONE;
          if (pend_q) begin
            ratio_act <= ratio_sh;
            high_act  <= high_sh;
            pend_q    <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + ONE;
        end
        if (wr_hit) begin
          ratio_sh <= wr_ratio_fix;
          high_sh  <= wr_high;
          pend_q   <= 1'b1;
        end
      end
    end

    assign divided[i] = div_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - scoreboard bench for multi_clock_divider
module tb_multi_clock_divider;

  localparam int CH = 2;
  localparam int W  = 16;

  typedef struct packed {
    logic [CH-1:0] d;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          sync;
  logic          wr_en;
  logic [0:0]    wr_ch;
  logic [W-1:0]  wr_ratio, wr_high;
  logic [CH-1:0] divided, tick, pending;

  logic [2:0]    en3, div3, tick3, pend3;
  logic          wr_en3;
  logic [1:0]    wr_ch3;
  logic [W-1:0]  wr_ratio3, wr_high3;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];
  int   m_pos[CH], m_ratio[CH], m_high[CH], m_sr[CH], m_sh[CH];
  bit   m_pend[CH];

  always #5 clk = ~clk;

  multi_clock_divider #(.CHANNELS(2), .WIDTH(16), .DEFAULT_RATIO(10), .DEFAULT_HIGH(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_ratio(wr_ratio), .wr_high(wr_high), .divided(divided), .tick(tick), .pending(pending)
  );

  multi_clock_divider #(.CHANNELS(3), .WIDTH(16), .DEFAULT_RATIO(10), .DEFAULT_HIGH(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .sync(1'b0), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_ratio(wr_ratio3), .wr_high(wr_high3), .divided(div3), .tick(tick3), .pending(pend3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 0; m_ratio[i] = 10; m_high[i] = 5;
      m_sr[i] = 10; m_sh[i] = 5; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input int i);
    if (m_pend[i]) begin
      m_ratio[i] = m_sr[i];
      m_high[i]  = m_sh[i];
      m_pend[i]  = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus, predict its registered outputs, then compare after the edge.
  task automatic cycle(input logic [CH-1:0] e, input logic s, input logic we,
                       input int ch, input int r, input int h);
    exp_t x;
    logic [31:0] chv;
    chv = ch;
    en = e; sync = s; wr_en = we; wr_ch = chv[0:0];
    wr_ratio = W'(r); wr_high = W'(h);
    x = '0;
    for (int i = 0; i < CH; i++) begin
      if (s || !e[i]) begin
        m_pos[i] = 0;
        model_apply(i);
      end else begin
        x.t[i] = (m_pos[i] == 0);
        x.d[i] = (m_pos[i] < m_high[i]);
        m_pos[i]++;
        if (m_pos[i] >= m_ratio[i]) begin
          m_pos[i] = 0;
          model_apply(i);
        end
      end
      if (we && ch == i) begin
        m_sr[i] = (r == 0) ? 1 : r;
        m_sh[i] = h;
        m_pend[i] = 1'b1;
      end
      x.p[i] = m_pend[i];
    end
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("sb_divided", 32'(divided), 32'(x.d));
    chk("sb_tick",    32'(tick),    32'(x.t));
    chk("sb_pending", 32'(pending), 32'(x.p));
    wr_en = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input logic [CH-1:0] e);
    cycle(e, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ntick;
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_ratio = '0; wr_high = '0;
    en3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_ratio3 = '0; wr_high3 = '0;
    model_reset();
    #3;
    chk("rst_divided", 32'(divided), 0);
    chk("rst_tick",    32'(tick),    0);
    chk("rst_pending", 32'(pending), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Defaults: 5 high / 5 low, tick on cycles 1, 11, 21
    for (int k = 1; k <= 25; k++) begin
      idle(2'b11);
      chk("def_tick",    32'(tick),    (((k - 1) % 10) == 0) ? 3 : 0);
      chk("def_divided", 32'(divided), (((k - 1) % 10) < 5) ? 3 : 0);
    end

    // Mid-period write to ch1: current period finishes, then 1 high / 3 low
    cycle(2'b11, 1'b0, 1'b1, 1, 4, 1);
    chk("wr1_pending", 32'(pending), 2);
    for (int k = 0; k < 20; k++) idle(2'b11);

    // Write ch0 on its boundary cycle, overwrite before next boundary
    for (int k = 0; k < 12 && m_pos[0] != m_ratio[0] - 1; k++) idle(2'b11);
    cycle(2'b11, 1'b0, 1'b1, 0, 6, 2);
    chk("bnd_pending", 32'(pending[0]), 1);
    cycle(2'b11, 1'b0, 1'b1, 0, 8, 3);
    for (int k = 0; k < 30; k++) idle(2'b11);

    // Degenerate values
    cycle(2'b11, 1'b0, 1'b1, 0, 0, 0);
    cycle(2'b11, 1'b0, 1'b1, 1, 3, 5);
    for (int k = 0; k < 20 && (m_pend[0] || m_pend[1]); k++) idle(2'b11);
    ntick = 0;
    for (int k = 0; k < 6; k++) begin
      idle(2'b11);
      chk("deg_tick0", 32'(tick[0]), 1);
      chk("deg_div0",  32'(divided[0]), 0);
      chk("deg_div1",  32'(divided[1]), 1);
      ntick += int'(tick[1]);
    end
    chk("deg_tick1_count", ntick, 2);

    // Out-of-range channel on a 3-channel instance
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_ratio3 = 16'd4; wr_high3 = 16'd1;
    idle(2'b11);
    wr_en3 = 1'b0;
    chk("bad_ch_pending", 32'(pend3), 0);
    wr_en3 = 1'b1; wr_ch3 = 2'd2;
    idle(2'b11);
    wr_en3 = 1'b0;
    chk("ch2_pending", 32'(pend3), 4);

    // Ratios 7 and 10, then sync
    cycle(2'b11, 1'b0, 1'b1, 0, 7, 3);
    cycle(2'b11, 1'b0, 1'b1, 1, 10, 5);
    for (int k = 0; k < 25; k++) idle(2'b11);
    cycle(2'b11, 1'b1, 1'b0, 0, 0, 0);
    chk("sync_divided", 32'(divided), 0);
    chk("sync_tick",    32'(tick),    0);
    idle(2'b11);
    chk("sync_align_tick", 32'(tick), 3);
    for (int k = 0; k < 12; k++) idle(2'b11);

    // Drop en[0] mid-high while pending
    for (int k = 0; k < 8 && m_pos[0] != 1; k++) idle(2'b11);
    cycle(2'b11, 1'b0, 1'b1, 0, 5, 2);
    chk("dis_pend_set", 32'(pending[0]), 1);
    for (int k = 0; k < 3; k++) begin
      idle(2'b10);
      chk("dis_divided0", 32'(divided[0]), 0);
      chk("dis_pending0", 32'(pending[0]), 0);
    end
    idle(2'b11);
    chk("reen_tick0", 32'(tick[0]), 1);
    chk("reen_div0",  32'(divided[0]), 1);
    for (int k = 0; k < 10; k++) idle(2'b11);

    // Asynchronous reset mid-period
    cycle(2'b11, 1'b0, 1'b1, 1, 3, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_divided", 32'(divided), 0);
    chk("arst_tick",    32'(tick),    0);
    chk("arst_pending", 32'(pending), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      idle(2'b11);
      chk("post_tick", 32'(tick), (((k - 1) % 10) == 0) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
